// File: rtl/jtframe_rom_arb_pkg.sv
// jtframe_rom_arb_pkg: shared FSM type, default ROM widths and round-robin search
package jtframe_rom_arb_pkg;
    localparam int ROM_AW = 22;
    localparam int ROM_DW = 32;

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } grant_t;

    // first set bit of pend strictly after last, wrapping at n (n <= 8)
    function automatic grant_t rr_grant(input logic [7:0] pend, input logic [2:0] last,
                                        input int unsigned n);
        grant_t      g;
        int unsigned k;
        g = '0;
        for (int unsigned j = 1; j <= 8; j++) begin
            k = (32'(last) + j) % n;
            if (j <= n && !g.found && pend[k[2:0]]) begin
                g.found = 1'b1;
                g.idx   = k[2:0];
            end
        end
        return g;
    endfunction
endpackage

// File: rtl/jtframe_rom_arb_slot.sv
// jtframe_rom_arb_slot: one-entry read cache and hit compare for a single requester
module jtframe_rom_arb_slot
    import jtframe_rom_arb_pkg::*;
#(
    parameter int AW = ROM_AW,
    parameter int DW = ROM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          downloading,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          wr,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          ok,
    output logic          pend,
    output logic [DW-1:0] dout
);
    logic          valid_q, valid_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;

    always_comb begin
        valid_d = downloading ? 1'b0 : (wr | valid_q);
        addr_d  = wr ? wr_addr : addr_q;
        data_d  = wr ? wr_data : data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign ok   = cs & valid_q & (addr_q == addr) & ~downloading;
    assign pend = cs & ~ok;
    assign dout = data_q;
endmodule

// File: rtl/jtframe_rom_arb.sv
// jtframe_rom_arb: round-robin sharing of one SDRAM read port among N cached ROM slots
module jtframe_rom_arb
    import jtframe_rom_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int AW = ROM_AW,
    parameter int DW = ROM_DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            downloading,
    input  logic [N-1:0]    slot_cs,
    input  logic [N*AW-1:0] slot_addr,
    output logic [N-1:0]    slot_ok,
    output logic [N*DW-1:0] slot_dout,
    output logic            sdram_req,
    output logic [AW-1:0]   sdram_addr,
    input  logic            sdram_ack,
    input  logic [DW-1:0]   data_read,
    input  logic            data_rdy,
    output logic            refresh_en
);
    state_t        state_q, state_d;
    logic [2:0]    gnt_q, gnt_d, last_q, last_d;
    logic          req_q, req_d;
    logic [AW-1:0] addr_q, addr_d, sel_addr;
    logic [N-1:0]  pend, wr;
    logic          done;
    grant_t        nxt;

    for (genvar i = 0; i < N; i++) begin : g_slot
        // a download discards in-flight data so stale ROM is never cached
        assign wr[i] = done & ~downloading & (gnt_q == 3'(i));
        jtframe_rom_arb_slot #(.AW(AW), .DW(DW)) u_slot (
            .clk         (clk),
            .rst         (rst),
            .downloading (downloading),
            .cs          (slot_cs[i]),
            .addr        (slot_addr[i*AW +: AW]),
            .wr          (wr[i]),
            .wr_addr     (addr_q),
            .wr_data     (data_read),
            .ok          (slot_ok[i]),
            .pend        (pend[i]),
            .dout        (slot_dout[i*DW +: DW])
        );
    end

    always_comb begin
        nxt      = rr_grant(8'(pend), last_q, N);
        sel_addr = '0;
        for (int i = 0; i < N; i++)
            if (nxt.idx == 3'(i)) sel_addr = slot_addr[i*AW +: AW];
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        req_d   = req_q;
        addr_d  = addr_q;
        done    = 1'b0;
        case (state_q)
            IDLE: if (nxt.found && !downloading) begin
                gnt_d   = nxt.idx;
                last_d  = nxt.idx;
                addr_d  = sel_addr;
                req_d   = 1'b1;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: if (sdram_ack) begin
                req_d   = 1'b0;
                done    = data_rdy;
                state_d = data_rdy ? IDLE : WAIT_DATA;
            end
            WAIT_DATA: if (data_rdy) begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= 3'(N-1);
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;
    assign refresh_en = (state_q == IDLE) & (~|pend | downloading);
endmodule

// File: tb/tb_jtframe_rom_arb.sv
// tb_jtframe_rom_arb: directed stimulus checked every cycle against a transaction-level model
module tb_jtframe_rom_arb;
    localparam int N = 4, AW = 22, DW = 32;

    logic            clk = 0, rst = 1, downloading = 0, sdram_ack = 0, data_rdy = 0;
    logic [N-1:0]    slot_cs = '0;
    logic [N*AW-1:0] slot_addr = '0;
    logic [DW-1:0]   data_read = '0;
    logic [N-1:0]    slot_ok;
    logic [N*DW-1:0] slot_dout;
    logic            sdram_req, refresh_en;
    logic [AW-1:0]   sdram_addr;
    int              checks = 0, failures = 0;

    always #5 clk = ~clk;

    jtframe_rom_arb #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .downloading(downloading), .slot_cs(slot_cs),
        .slot_addr(slot_addr), .slot_ok(slot_ok), .slot_dout(slot_dout),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
        .data_read(data_read), .data_rdy(data_rdy), .refresh_en(refresh_en)
    );

    // model: per-slot cache contents plus one outstanding transaction
    logic          m_valid[N];
    logic [AW-1:0] m_addr[N];
    logic [DW-1:0] m_data[N];
    logic          m_busy, m_acked;
    int            m_gnt, m_last;
    logic [AW-1:0] m_req_addr;
    logic [AW-1:0] got[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] m_hit();
        logic [N-1:0] h;
        for (int i = 0; i < N; i++)
            h[i] = slot_cs[i] && m_valid[i] && (m_addr[i] == slot_addr[i*AW +: AW]) && !downloading;
        return h;
    endfunction

    always @(posedge clk) begin
        logic [N-1:0] pnd;
        int           k;
        logic         fin;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 0; m_addr[i] = '0; m_data[i] = '0;
            end
            m_busy = 0; m_acked = 0; m_gnt = 0; m_last = N-1; m_req_addr = '0;
        end else begin
            pnd = slot_cs & ~m_hit();
            fin = 0;
            if (!m_busy) begin
                if (pnd != 0 && !downloading)
                    for (int j = 1; j <= N; j++) begin
                        k = (m_last + j) % N;
                        if (pnd[k] && !m_busy) begin
                            m_busy = 1; m_acked = 0; m_gnt = k; m_last = k;
                            m_req_addr = slot_addr[k*AW +: AW];
                        end
                    end
            end else if (!m_acked) begin
                if (sdram_ack) begin m_acked = 1; fin = data_rdy; end
            end else fin = data_rdy;
            if (fin) begin
                m_busy = 0;
                if (!downloading) begin
                    m_valid[m_gnt] = 1; m_addr[m_gnt] = m_req_addr; m_data[m_gnt] = data_read;
                end
            end
            if (downloading) for (int i = 0; i < N; i++) m_valid[i] = 0;
        end
    end

    always @(negedge clk) if (!rst) begin
        chk("slot_ok", slot_ok, m_hit());
        chk("sdram_req", sdram_req, m_busy && !m_acked);
        if (m_busy && !m_acked) chk("sdram_addr", sdram_addr, m_req_addr);
        chk("refresh_en", refresh_en, !m_busy && (((slot_cs & ~m_hit()) == 0) || downloading));
        for (int i = 0; i < N; i++) chk("slot_dout", slot_dout[i*DW +: DW], m_data[i]);
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic set_slot(input int i, input logic cs, input logic [AW-1:0] a);
        slot_cs[i] = cs;
        slot_addr[i*AW +: AW] = a;
    endtask

    task automatic wait_req();
        int t = 0;
        while (!sdram_req && t < 50) begin cyc(); t++; end
        chk("req_seen", sdram_req, 1);
        if (sdram_req) got.push_back(sdram_addr);
    endtask

    task automatic ack_pulse(input logic with_rdy, input logic [DW-1:0] d);
        sdram_ack = 1; data_rdy = with_rdy; data_read = d;
        cyc();
        sdram_ack = 0; data_rdy = 0;
    endtask

    task automatic rdy_pulse(input logic [DW-1:0] d);
        data_rdy = 1; data_read = d;
        cyc();
        data_rdy = 0;
    endtask

    task automatic serve(input int da, input int dr, input logic [DW-1:0] d);
        wait_req();
        cyc(da);
        if (dr == 0) ack_pulse(1, d);
        else begin
            ack_pulse(0, d);
            cyc(dr - 1);
            rdy_pulse(d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] exp3[6];
        exp3 = '{22'h10, 22'h20, 22'h30, 22'h31, 22'h11, 22'h21};
        cyc(3);
        chk("rst_req", sdram_req, 0);
        chk("rst_ok", slot_ok, 0);
        chk("rst_refresh", refresh_en, 1);
        chk("rst_addr", sdram_addr, 0);
        rst = 0;
        cyc();
        // single miss then hit
        set_slot(0, 1, 22'h100);
        #1 chk("t1_refresh_pend", refresh_en, 0);
        serve(2, 4, 32'hDEADBEEF);
        #1;
        chk("t1_addr", got.pop_front(), 22'h100);
        chk("t1_ok", slot_ok[0], 1);
        chk("t1_dout", slot_dout[31:0], 32'hDEADBEEF);
        chk("t1_refresh", refresh_en, 1);
        set_slot(0, 0, 22'h0);
        cyc();
        set_slot(0, 1, 22'h100);
        #1 chk("t2_ok", slot_ok[0], 1);
        cyc(3);
        chk("t2_req", sdram_req, 0);
        set_slot(0, 0, 22'h0);
        // round-robin order
        rst = 1;
        cyc();
        rst = 0;
        cyc();
        set_slot(0, 1, 22'h10); set_slot(1, 1, 22'h20); set_slot(2, 1, 22'h30);
        serve(1, 1, 32'hA0000010);
        serve(1, 1, 32'hA0000020);
        serve(1, 1, 32'hA0000030);
        slot_cs = '0;
        cyc();
        set_slot(0, 1, 22'h11); set_slot(1, 1, 22'h21); set_slot(3, 1, 22'h31);
        serve(0, 2, 32'hB0000031);
        serve(0, 2, 32'hB0000011);
        serve(0, 2, 32'hB0000021);
        slot_cs = '0;
        chk("t3_count", 64'(got.size()), 6);
        for (int i = 0; i < 6 && i < got.size(); i++) chk("t3_order", got[i], exp3[i]);
        got.delete();
        cyc();
        // address change while waiting for data
        set_slot(1, 1, 22'h40);
        wait_req();
        cyc();
        ack_pulse(0, 32'h0);
        set_slot(1, 1, 22'h44);
        cyc();
        rdy_pulse(32'h40404040);
        #1;
        chk("t4_ok", slot_ok[1], 0);
        chk("t4_dout", slot_dout[63:32], 32'h40404040);
        wait_req();
        chk("t4_reissue", sdram_addr, 22'h44);
        cyc();
        ack_pulse(1, 32'h44444444);
        #1 chk("t4_ok2", slot_ok[1], 1);
        slot_cs = '0;
        cyc();
        // download during an in-flight read
        set_slot(2, 1, 22'h50);
        wait_req();
        ack_pulse(0, 32'h0);
        downloading = 1;
        cyc(2);
        rdy_pulse(32'h55555555);
        cyc(3);
        #1;
        chk("t5_req", sdram_req, 0);
        chk("t5_ok", slot_ok, 0);
        chk("t5_refresh", refresh_en, 1);
        chk("t5_dout", slot_dout[95:64], 32'hA0000030);
        downloading = 0;
        wait_req();
        chk("t5_remiss", sdram_addr, 22'h50);
        cyc();
        ack_pulse(0, 32'h0);
        rdy_pulse(32'h50505050);
        #1 chk("t5_ok2", slot_ok[2], 1);
        slot_cs = '0;
        cyc();
        // ack and data in the same cycle
        set_slot(0, 1, 22'h60); set_slot(1, 1, 22'h70);
        wait_req();
        chk("t6_first", sdram_addr, 22'h60);
        ack_pulse(1, 32'h60606060);
        #1;
        chk("t6_ok0", slot_ok[0], 1);
        chk("t6_gap", sdram_req, 0);
        cyc();
        chk("t6_next_req", sdram_req, 1);
        chk("t6_next_addr", sdram_addr, 22'h70);
        cyc();
        ack_pulse(0, 32'h0);
        rdy_pulse(32'h70707070);
        #1 chk("t6_both", slot_ok[1:0], 2'b11);
        slot_cs = '0;
        cyc(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
